// File: rtl/alu_burst_sequencer_pkg.sv
// alu_pkg: opcode constants and sequencer FSM encoding shared by the burst datapath.
package alu_pkg;
    localparam int OP_ADD = 0;
    localparam int OP_SUB = 1;
    localparam int OP_NOT = 2;
    localparam int OP_SHL = 3;
    localparam int OP_MAX = 3;
    typedef enum logic {ST_IDLE, ST_BURST} state_t;
endpackage

// File: rtl/alu_burst_sequencer_fifo.sv
// alu_res_fifo: synchronous show-ahead FIFO with occupancy count.
// When empty, o_data holds the most recently popped entry (0 after reset).
module alu_res_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_hold;
    logic [AW-1:0]    r_wr, r_rd;
    logic [AW:0]      r_count;
    logic             w_pop;

    assign w_pop   = i_pop && r_count != '0;
    assign o_data  = r_count != '0 ? r_mem[r_rd] : r_hold;
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (i_push)
            r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_hold  <= '0;
        end else begin
            if (i_push)
                r_wr <= r_wr + 1'b1;
            if (w_pop) begin
                r_rd   <= r_rd + 1'b1;
                r_hold <= r_mem[r_rd];
            end
            r_count <= r_count + {{AW{1'b0}}, i_push} - {{AW{1'b0}}, w_pop};
        end
    end
endmodule

// File: rtl/alu_burst_sequencer.sv
// alu_burst_sequencer: registers burst beats into an external ALU and streams
// its results out through a small FIFO with burst framing and length policing.
module alu_burst_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [DATA_WIDTH-1:0]        s_op1,
    input  logic [DATA_WIDTH-1:0]        s_op2,
    input  logic [DATA_WIDTH-1:0]        s_opcode,
    input  logic                         s_last,
    output logic [DATA_WIDTH-1:0]        alu_op1,
    output logic [DATA_WIDTH-1:0]        alu_op2,
    output logic [DATA_WIDTH-1:0]        alu_opcode,
    input  logic [DATA_WIDTH-1:0]        alu_result,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DATA_WIDTH-1:0]        m_result,
    output logic                         m_last,
    output logic [$clog2(MAX_BURST)-1:0] m_beat,
    output logic                         len_err,
    output logic                         op_err,
    output logic [15:0]                  bursts_done
);
    localparam int BW = $clog2(MAX_BURST);
    localparam int FW = DATA_WIDTH + 1 + BW;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t          r_state, w_state_nxt;
    logic [BW-1:0]   r_cnt, r_if_beat, w_idx;
    logic            r_in_flight, r_if_last, r_len_err, r_op_err;
    logic [15:0]     r_bursts;
    logic            w_acc, w_cap, w_last, w_pop;
    logic [CW-1:0]   w_count;
    logic [FW-1:0]   w_head;

    assign w_idx   = r_state == ST_BURST ? r_cnt : '0;
    assign w_cap   = w_idx == BW'(MAX_BURST - 1);
    assign w_last  = s_last || w_cap;
    // Occupancy counts the beat still inside the ALU so the FIFO can never overflow.
    assign s_ready = !rst && (w_count + CW'(r_in_flight)) < CW'(FIFO_DEPTH);
    assign w_acc   = s_valid && s_ready;
    assign m_valid = w_count != '0;
    assign w_pop   = m_valid && m_ready;
    assign {m_result, m_last, m_beat} = w_head;
    assign len_err     = r_len_err;
    assign op_err      = r_op_err;
    assign bursts_done = r_bursts;

    always_comb begin
        w_state_nxt = r_state;
        if (w_acc)
            w_state_nxt = w_last ? ST_IDLE : ST_BURST;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_in_flight <= 1'b0;
            r_if_last   <= 1'b0;
            r_if_beat   <= '0;
            alu_op1     <= '0;
            alu_op2     <= '0;
            alu_opcode  <= '0;
            r_len_err   <= 1'b0;
            r_op_err    <= 1'b0;
            r_bursts    <= '0;
        end else begin
            r_in_flight <= w_acc;
            if (w_acc) begin
                alu_op1    <= s_op1;
                alu_op2    <= s_op2;
                alu_opcode <= s_opcode;
                r_if_last  <= w_last;
                r_if_beat  <= w_idx;
                r_cnt      <= w_last ? '0 : w_idx + 1'b1;
            end
            if (w_acc && w_cap && !s_last)
                r_len_err <= 1'b1;
            if (w_acc && s_opcode > DATA_WIDTH'(OP_MAX))
                r_op_err <= 1'b1;
            if (w_pop && m_last)
                r_bursts <= r_bursts + 1'b1;
        end
    end

    alu_res_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_in_flight),
        .i_data  ({alu_result, r_if_last, r_if_beat}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count)
    );
endmodule

// File: doc/alu_burst_sequencer.md
# alu_burst_sequencer

Sequencer that sits directly upstream of the combinational `alu` in the AXI_MM_BURST datapath. It accepts bursts of operand/opcode beats on a valid/ready stream and registers each beat into the ALU operand ports. It captures the ALU result one cycle later into a small result FIFO and emits results as a valid/ready stream with burst framing preserved. It enforces a maximum burst length and flags illegal opcodes.

## Interface
Parameters:
- `DATA_WIDTH`, 8, operand, opcode and result width; must equal the `alu` instance's `DATA_WIDTH`.
- `MAX_BURST`, 16, maximum beats per burst (≥2).
- `FIFO_DEPTH`, 4, result FIFO entries (power of two, ≥2).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `s_valid`  in  1  input beat valid.
- `s_ready`  out  1  input beat accepted when `s_valid && s_ready`.
- `s_op1`, `s_op2`, `s_opcode`  in  DATA_WIDTH each  beat payload.
- `s_last`  in  1  final beat of burst.
- `alu_op1`, `alu_op2`, `alu_opcode`  out  DATA_WIDTH each  registered operands to `alu`.
- `alu_result`  in  DATA_WIDTH  combinational result from `alu`.
- `m_valid`  out  1  result beat valid.
- `m_ready`  in  1  downstream accept.
- `m_result`  out  DATA_WIDTH  result data.
- `m_last`  out  1  final result of burst.
- `m_beat`  out  $clog2(MAX_BURST)  beat index within burst, 0-based.
- `len_err`  out  1  sticky: a burst was truncated at MAX_BURST.
- `op_err`  out  1  sticky: an opcode > 3 was accepted.
- `bursts_done`  out  16  count of `m_last` handshakes, wraps 0xFFFF→0.

## Operation
- Reset: all outputs 0 (`s_ready` 0 during the reset cycle, 1 the cycle after), FIFO emptied, in-flight beat discarded, FSM to IDLE, sticky flags and counters cleared. Reset mid-burst drops the burst; no partial `m_last` is produced.
- FSM states: IDLE (no open burst), BURST (≥1 beat accepted, no last yet).
  - IDLE→BURST on an accepted beat with effective last = 0.
  - BURST→IDLE on an accepted beat with effective last = 1.
  - IDLE→IDLE on a single-beat burst (`s_last`=1 on beat 0).
- Beat counter: 0 on entry to IDLE; increments per accepted beat. Effective last = `s_last` OR (counter == MAX_BURST-1). If the forced case applies with `s_last`=0, set `len_err`; the next input beat starts a new burst at index 0.
- Stage 1, accept edge: load `alu_op*` from the payload; latch `in_flight`, last and index.
- Stage 2, next edge: push {`alu_result`, last, index} into the FIFO. `alu_op*` hold their value until the next accepted beat.
- `op_err` is set when an accepted `s_opcode` > 3. The beat still flows; the ALU returns 0.
- Flow control: `s_ready` = (fifo_count + in_flight) < FIFO_DEPTH, computed from registers only, with no combinational path from `m_ready`. The FIFO never overflows. Push and pop in the same cycle are both honoured.
- Output: the FIFO head drives `m_*` directly (show-ahead). `m_result`/`m_last`/`m_beat` are stable while `m_valid && !m_ready`. `bursts_done` increments on `m_valid && m_ready && m_last`.

## Timing
- Latency: a beat accepted at edge N gives `alu_op*` valid after N. The FIFO write occurs at N+1, and `m_valid` is high in the cycle after N+1. Total: 2 cycles edge-to-valid.
- Throughput: 1 beat/cycle sustained when `m_ready`=1.
- With `m_ready` held low: exactly FIFO_DEPTH beats accepted, then `s_ready`=0. `s_ready` returns the cycle after the first pop.
- Empty FIFO: `m_valid`=0 and `m_*` hold their last value (0 after reset).

## Structure
- Package `alu_pkg`:
  - Opcode constants `OP_ADD`=0, `OP_SUB`=1, `OP_NOT`=2, `OP_SHL`=3.
  - `OP_MAX`=3.
  - FSM state encoding IDLE/BURST.
- Sub-module `alu_res_fifo`: synchronous show-ahead FIFO, parameterised width/depth, with count output. The `alu` itself is instantiated by the parent, not inside this block.

## Test plan
- 4-beat burst, `m_ready`=1. Beats (5,3,op0), (5,3,op1), (0x0F,x,op2), (1,3,op3) → results 8, 2, 0xF0, 8. `m_beat` 0..3, `m_last` only on beat 3, `bursts_done`=1. First `m_valid` 2 cycles after the first accept.
- Backpressure: `m_ready`=0 while streaming 6 beats → exactly 4 accepted, `s_ready`=0. Release `m_ready` → all 6 results appear in order with no loss or duplication.
- 17 beats, `s_last` never asserted, MAX_BURST=16 → beat 15 has `m_last`=1 and `len_err`=1. Beat 16 emerges with `m_beat`=0.
- Opcode 7 with op1=9, op2=9 → `m_result`=0 and `op_err`=1, sticky until reset.
- Reset asserted after 2 beats of a burst and 1 pending result → all outputs 0 the following cycle. The next burst starts at `m_beat`=0 and `bursts_done`=0.
- 0x10000 single-beat bursts → `bursts_done` wraps to 0.
